// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: write port, two read ports, scoreboard reserve and clear control.
// The master drives addresses, data and commands; the slave returns read data, pending bits and busy.
interface regfile_sb_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              write;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] in;
    logic [ADDR_W-1:0] r_addr1;
    logic [ADDR_W-1:0] r_addr2;
    logic [DATA_W-1:0] out1;
    logic [DATA_W-1:0] out2;
    logic              reserve;
    logic [ADDR_W-1:0] res_addr;
    logic              pend1;
    logic              pend2;
    logic              clr;
    logic              busy;

    modport master (
        output write, w_addr, in, r_addr1, r_addr2, reserve, res_addr, clr,
        input  out1, out2, pend1, pend2, busy
    );

    modport slave (
        input  write, w_addr, in, r_addr1, r_addr2, reserve, res_addr, clr,
        output out1, out2, pend1, pend2, busy
    );
endinterface

// File: rtl/regfile_sb.sv
// Register file with a per-entry pending-write scoreboard and a one-entry-per-cycle clear sweep.
// Optional feature macro REGFILE_BYPASS_EN: forwards the in-flight write to matching read ports.
module regfile_sb #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic          clk,
    input  logic          rst,
    regfile_sb_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;

    logic [DATA_W-1:0] mem_view  [DEPTH];
    logic [DEPTH-1:0]  pend_view;

    logic idle;
    logic start_clr;
    logic wr_ok;
    logic rs_ok;

    // A clr edge in IDLE swallows that cycle's write and reserve.
    assign idle      = (state_reg == IDLE);
    assign start_clr = idle && bus.clr;
    assign wr_ok     = idle && !bus.clr && bus.write;
    assign rs_ok     = idle && !bus.clr && bus.reserve;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (bus.clr) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            CLEAR: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == ADDR_W'(DEPTH - 1)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [DATA_W-1:0] data_reg;
            logic              pend_reg;
            logic              sweep_hit;
            logic              wr_hit;
            logic              rs_hit;

            assign sweep_hit = (state_reg == CLEAR) && (cnt_reg == ADDR_W'(gi));
            assign wr_hit    = wr_ok && (bus.w_addr == ADDR_W'(gi));
            assign rs_hit    = rs_ok && (bus.res_addr == ADDR_W'(gi));

            // Reserve is checked before write so a same-cycle reserve leaves the entry pending.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_reg <= '0;
                    pend_reg <= 1'b0;
                end else begin
                    if (sweep_hit) begin
                        data_reg <= '0;
                    end else if (wr_hit) begin
                        data_reg <= bus.in;
                    end

                    if (start_clr) begin
                        pend_reg <= 1'b0;
                    end else if (rs_hit) begin
                        pend_reg <= 1'b1;
                    end else if (wr_hit) begin
                        pend_reg <= 1'b0;
                    end
                end
            end

            assign mem_view[gi]  = data_reg;
            assign pend_view[gi] = pend_reg;
        end
    endgenerate

    assign bus.busy = (state_reg == CLEAR);

    always_comb begin
        bus.out1  = mem_view[bus.r_addr1];
        bus.out2  = mem_view[bus.r_addr2];
        bus.pend1 = pend_view[bus.r_addr1];
        bus.pend2 = pend_view[bus.r_addr2];
`ifdef REGFILE_BYPASS_EN
        // Forwarded reads see the post-edge view: new data, pending only if reserved too.
        if (bus.write && idle && (bus.r_addr1 == bus.w_addr)) begin
            bus.out1  = bus.in;
            bus.pend1 = bus.reserve && (bus.res_addr == bus.w_addr);
        end
        if (bus.write && idle && (bus.r_addr2 == bus.w_addr)) begin
            bus.out2  = bus.in;
            bus.pend2 = bus.reserve && (bus.res_addr == bus.w_addr);
        end
`endif
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: a reference model feeds expected values into a queue
// that is drained as DUT outputs are sampled.
module tb_regfile_sb;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    logic clk = 1'b0;
    logic rst;

    regfile_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t       sb_q [$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] mdl [DEPTH];
    logic       mp  [DEPTH];
    int         n_busy;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic pop_cmp(input logic [15:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL sb_underflow: got 0x%0h, want no sample", obs);
        end else begin
            e = sb_q.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_read(input logic [2:0] a1, input logic [2:0] a2, input string tag);
        bus.r_addr1 = a1;
        bus.r_addr2 = a2;
        push($sformatf("%s_out1_r%0d", tag, a1), 16'(mdl[a1]));
        push($sformatf("%s_out2_r%0d", tag, a2), 16'(mdl[a2]));
        push($sformatf("%s_pend1_r%0d", tag, a1), 16'(mp[a1]));
        push($sformatf("%s_pend2_r%0d", tag, a2), 16'(mp[a2]));
        #1;
        $display("read  %s r%0d=0x%02h p%0b  r%0d=0x%02h p%0b", tag, a1, bus.out1, bus.pend1,
                 a2, bus.out2, bus.pend2);
        pop_cmp(16'(bus.out1));
        pop_cmp(16'(bus.out2));
        pop_cmp(16'(bus.pend1));
        pop_cmp(16'(bus.pend2));
    endtask

    task automatic check_busy(input logic exp, input string tag);
        push(tag, 16'(exp));
        pop_cmp(16'(bus.busy));
    endtask

    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        bus.write  = 1'b1;
        bus.w_addr = a;
        bus.in     = d;
        cyc();
        bus.write  = 1'b0;
        mdl[a] = d;
        mp[a]  = 1'b0;
        $display("write r%0d <= 0x%02h", a, d);
    endtask

    task automatic do_reserve(input logic [2:0] a);
        bus.reserve  = 1'b1;
        bus.res_addr = a;
        cyc();
        bus.reserve  = 1'b0;
        mp[a] = 1'b1;
        $display("reserve r%0d", a);
    endtask

    task automatic model_zero();
        for (int i = 0; i < DEPTH; i++) begin
            mdl[i] = 8'h00;
            mp[i]  = 1'b0;
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.write    = 1'b0;
        bus.w_addr   = '0;
        bus.in       = '0;
        bus.r_addr1  = '0;
        bus.r_addr2  = '0;
        bus.reserve  = 1'b0;
        bus.res_addr = '0;
        bus.clr      = 1'b0;
        model_zero();

        // Reset state
        cyc();
        cyc();
        for (int a = 0; a < DEPTH; a++) check_read(3'(a), 3'(7 - a), "rst");
        check_busy(1'b0, "rst_busy");
        @(negedge clk);
        rst = 1'b0;
        cyc();

        // Write and readback
        do_write(3'd3, 8'hA5);
        check_read(3'd3, 3'd7, "wr1");
        do_write(3'd7, 8'h3C);
        check_read(3'd3, 3'd7, "wr2");

        // Same-cycle read of the entry being written
        do_write(3'd2, 8'h22);
        do_reserve(3'd2);
        bus.r_addr1 = 3'd2;
        bus.r_addr2 = 3'd3;
        bus.write   = 1'b1;
        bus.w_addr  = 3'd2;
        bus.in      = 8'h5A;
`ifdef REGFILE_BYPASS_EN
        push("byp_out1", 16'h005A);
        push("byp_pend1", 16'h0000);
`else
        push("byp_out1", 16'h0022);
        push("byp_pend1", 16'h0001);
`endif
        push("byp_out2", 16'(mdl[3]));
        #1;
        pop_cmp(16'(bus.out1));
        pop_cmp(16'(bus.pend1));
        pop_cmp(16'(bus.out2));
        cyc();
        bus.write = 1'b0;
        mdl[2] = 8'h5A;
        mp[2]  = 1'b0;
        check_read(3'd2, 3'd3, "byp_after");

        // Scoreboard
        do_reserve(3'd4);
        check_read(3'd4, 3'd3, "sb_res");
        do_write(3'd4, 8'h11);
        check_read(3'd4, 3'd3, "sb_wr");
        bus.write    = 1'b1;
        bus.w_addr   = 3'd5;
        bus.in       = 8'h99;
        bus.reserve  = 1'b1;
        bus.res_addr = 3'd5;
        cyc();
        bus.write   = 1'b0;
        bus.reserve = 1'b0;
        mdl[5] = 8'h99;
        mp[5]  = 1'b1;
        check_read(3'd5, 3'd4, "sb_both");
        do_reserve(3'd5);
        check_read(3'd5, 3'd5, "sb_rerun");

        // Clear sweep; the clr edge also carries a write and reserve that must be dropped
        for (int a = 0; a < DEPTH; a++) do_write(3'(a), 8'hFF);
        do_reserve(3'd6);
        do_reserve(3'd1);
        bus.clr      = 1'b1;
        bus.write    = 1'b1;
        bus.w_addr   = 3'd0;
        bus.in       = 8'h33;
        bus.reserve  = 1'b1;
        bus.res_addr = 3'd3;
        cyc();
        bus.clr     = 1'b0;
        bus.write   = 1'b0;
        bus.reserve = 1'b0;
        for (int i = 0; i < DEPTH; i++) mp[i] = 1'b0;
        check_busy(1'b1, "clr_busy_start");
        check_read(3'd0, 3'd3, "clr_edge");
        n_busy = 0;
        while (bus.busy && n_busy < 20) begin
            if (n_busy == 2) begin
                bus.write  = 1'b1;
                bus.w_addr = 3'd1;
                bus.in     = 8'h77;
            end
            cyc();
            bus.write = 1'b0;
            n_busy++;
        end
        $display("sweep busy cycles %0d", n_busy);
        push("sweep_len", 16'd8);
        pop_cmp(16'(n_busy));
        model_zero();
        for (int a = 0; a < DEPTH; a++) check_read(3'(a), 3'(a ^ 1), "swept");
        check_busy(1'b0, "sweep_done_busy");
        do_write(3'd0, 8'h42);
        check_read(3'd0, 3'd1, "post_sweep");

        // Reset in the middle of a sweep
        do_write(3'd5, 8'hAB);
        do_write(3'd6, 8'hCD);
        bus.clr = 1'b1;
        cyc();
        bus.clr = 1'b0;
        cyc();
        cyc();
        mdl[0] = 8'h00;
        mdl[1] = 8'h00;
        check_read(3'd0, 3'd5, "partial");
        check_busy(1'b1, "mid_busy");
        rst = 1'b1;
        #1;
        check_busy(1'b0, "rst_mid_busy");
        model_zero();
        for (int a = 0; a < DEPTH; a++) check_read(3'(a), 3'(7 - a), "rst_mid");
        @(negedge clk);
        rst = 1'b0;
        do_write(3'd5, 8'h5C);
        check_read(3'd5, 3'd6, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with one write port, two asynchronous read ports, a per-entry pending-write scoreboard and a multi-cycle clear sequencer. It is the next-generation general-purpose register bank for the CPU datapath. Width and depth are set by parameters. The scoreboard lets the issue stage stall on registers whose results are still in flight, and the clear sequencer zeroes the bank without a full reset.

## Interface
Parameters:
- DATA_W, default 8: entry width in bits.
- ADDR_W, default 3: address width; DEPTH = 2**ADDR_W entries.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- write  in  1  write enable.
- w_addr  in  ADDR_W  write address.
- in  in  DATA_W  write data.
- r_addr1, r_addr2  in  ADDR_W  read addresses.
- out1, out2  out  DATA_W  read data.
- reserve  in  1  mark entry res_addr as pending.
- res_addr  in  ADDR_W  address to reserve.
- pend1, pend2  out  1  pending bit of the entry at r_addr1 and r_addr2 respectively.
- clr  in  1  start clear sweep (level, sampled when idle).
- busy  out  1  clear sweep in progress.

## Operation
- Storage: DEPTH x DATA_W array, pend[DEPTH-1:0], state IDLE/CLEAR, and a sweep counter cnt[ADDR_W-1:0].
- IDLE, with write=1: at the clock edge, array[w_addr] <= in and pend[w_addr] <= 0.
- IDLE, with reserve=1: at the clock edge, pend[res_addr] <= 1.
- reserve and write to the same address in the same cycle: the pending bit ends set, because reserve wins. The data is still written.
- Reserving an entry that is already pending leaves it set. This is not an error.
- Transition IDLE -> CLEAR: clr=1 at an edge while in IDLE. At that edge:
  - cnt <= 0.
  - All pend bits are cleared.
  - That cycle's write and reserve are dropped.
- CLEAR: each edge performs array[cnt] <= 0 and cnt <= cnt+1.
  - write, reserve and clr are ignored.
- Transition CLEAR -> IDLE: at the edge that zeroes entry DEPTH-1. cnt wraps to 0.
- busy = (state == CLEAR).
- Reads are combinational: outN = array[r_addrN] and pendN = pend[r_addrN]. Forwarding under REGFILE_BYPASS_EN is the exception.
- Reads during CLEAR return the current array contents. These may be partially cleared.

## Timing
- On rst assertion, asynchronously:
  - All entries = 0 and all pend = 0.
  - state = IDLE, cnt = 0.
  - Resulting outputs: out1 = out2 = 0, pend1 = pend2 = 0, busy = 0.
- rst asserted mid-sweep aborts the sweep. The bank returns to IDLE, fully zeroed.
- Write latency is 1 edge: data is visible on the read ports after the write edge.
- Read latency is 0 cycles, combinational from the address inputs.
- Clear sweep: busy is high for exactly DEPTH cycles, starting after the clr edge. The first accepted write is at edge DEPTH+1 after the clr edge.
- Both read ports may address the same entry as each other, or as w_addr, with no restriction.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- With the macro defined (write-to-read forwarding):
  - If write=1, state is IDLE and r_addrN == w_addr, then outN = in and pendN = 0 in the same cycle, before the edge.
  - A simultaneous reserve to that address still forces pendN = 1.
- Without the macro: read ports show the stored value and stored pend bit until the write edge.
- The macro affects only the combinational read path. Sequential state is identical either way.

## Test plan
- Reset then read: assert rst; read all 8 addresses -> out1 = out2 = 0x00, pend1 = pend2 = 0, busy = 0.
- Write/readback: write 0xA5 to R3, 0x3C to R7; r_addr1=3, r_addr2=7 -> out1=0xA5, out2=0x3C one edge after each write.
- Bypass: write 0x5A to R2 with r_addr1=2 in the same cycle.
  - Defined: out1=0x5A before the edge.
  - Not defined: out1 shows the old value, then 0x5A after the edge.
- Scoreboard: reserve R4 -> pend1=1 (r_addr1=4); write R4=0x11 -> pend1=0 after the edge. Reserve and write R5 in the same cycle -> pend=1, data=value written.
- Clear sweep: fill all entries with 0xFF, pulse clr.
  - busy is high for exactly 8 cycles.
  - A write of 0x77 to R1 during the sweep is ignored.
  - Afterwards, all entries read 0x00 and all pend bits read 0.
- Reset mid-sweep: assert rst on sweep cycle 3 -> busy=0 immediately and all entries read 0x00. A write on the next edge is accepted.
